// File: rtl/cdic_pkg.sv
// CDIC shared definitions: register map offsets, command and sync codes,
// status bit positions, sequencer states and a byte-merge helper.
package cdic_pkg;

  localparam logic [2:0] REG_CMD    = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_LBA_HI = 3'd2;
  localparam logic [2:0] REG_LBA_LO = 3'd3;
  localparam logic [2:0] REG_DMACNT = 3'd4;
  localparam logic [2:0] REG_VECTOR = 3'd5;

  localparam logic [15:0] CMD_READ_SECTOR = 16'h0001;
  localparam logic [15:0] SYNC_WORD       = 16'h00FF;

  localparam int ST_READY    = 0;
  localparam int ST_REJECT   = 1;
  localparam int ST_DMA_DONE = 2;

  typedef enum logic [1:0] {IDLE, REQ, FILL, CHECK} state_t;

  function automatic logic [15:0] merge_bytes(input logic [15:0] old,
                                              input logic [15:0] wdata,
                                              input logic        uds,
                                              input logic        lds);
    return {uds ? wdata[15:8] : old[15:8], lds ? wdata[7:0] : old[7:0]};
  endfunction

endpackage

// File: rtl/cdic_sector_ram.sv
// Single-port sector buffer, one registered read per cycle (read-before-write).
module cdic_sector_ram #(
  parameter int WORDS = 1176,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cdic.sv
// CDIC: CPU-visible sector buffer and registers, HPS sector fetch sequencer.
// Optional DMA read-out engine is built when CDIC_DMA_EN is defined.
module cdic
  import cdic_pkg::*;
#(
  parameter int          SECTOR_WORDS = 1176,
  parameter logic [12:0] REG_BASE     = 13'h1FF8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [23:1]        address,
  input  logic [15:0]        din,
  output logic [15:0]        dout,
  input  logic               uds,
  input  logic               lds,
  input  logic               write_strobe,
  input  logic               cs,
  output logic               bus_ack,
  output logic               intreq,
  input  logic               intack,
  output logic               req,
  output logic               rdy,
  output logic               done_out,
  input  logic               ack,
  input  logic               dtc,
  input  logic               done_in,
  output logic [31:0]        cd_hps_lba,
  output logic               cd_hps_req,
  input  logic               cd_hps_ack,
  input  logic               cd_hps_data_valid,
  input  logic [15:0]        cd_hps_data,
  output logic signed [15:0] audio_left,
  output logic signed [15:0] audio_right,
  input  logic               debug_disable_sector_filter
);

  localparam int          AW       = $clog2(SECTOR_WORDS);
  localparam logic [12:0] LAST13   = 13'(SECTOR_WORDS - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(SECTOR_WORDS - 1);

  logic [12:0] offset, reg_off;
  logic        reg_hit, buf_hit, access, wr, rd;
  logic        cs_seen, rd_ram;
  logic [15:0] rd_q, reg_rdata, lba_hi, lba_lo, ram_q, ram_wdata, dmacnt_rd;
  logic [7:0]  vector;
  logic [2:0]  status, status_set, status_clr;
  state_t      state, state_nx;
  logic [AW-1:0] fill_idx, ram_addr, ptr_addr;
  logic [15:0] word0;
  logic        ram_we, cmd_go, check_pass, dma_finish, dma_rd;
  logic        unused_addr;

  assign offset  = address[13:1];
  assign reg_off = offset - REG_BASE;
  assign reg_hit = reg_off < 13'd6;
  assign buf_hit = offset <= LAST13;
  // One access per cs assertion: only the first sampled cycle counts.
  assign access  = cs && !cs_seen;
  assign wr      = access && write_strobe;
  assign rd      = access && !write_strobe;
  assign unused_addr = ^address[23:14];

  assign cmd_go = wr && reg_hit && reg_off[2:0] == REG_CMD && state == IDLE &&
                  merge_bytes(16'h0000, din, uds, lds) == CMD_READ_SECTOR;
  assign check_pass = (word0 == SYNC_WORD) || debug_disable_sector_filter;

  always_comb begin
    reg_rdata = '0;
    case (reg_off[2:0])
      REG_STATUS: reg_rdata = {13'd0, status};
      REG_LBA_HI: reg_rdata = lba_hi;
      REG_LBA_LO: reg_rdata = lba_lo;
      REG_DMACNT: reg_rdata = dmacnt_rd;
      REG_VECTOR: reg_rdata = {8'h00, vector};
      default:    reg_rdata = '0;
    endcase
  end

  // Bus stage: capture read data with the access, ack one cycle later
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_seen <= 1'b0;
      bus_ack <= 1'b0;
      rd_ram  <= 1'b0;
      rd_q    <= '0;
    end else begin
      cs_seen <= cs;
      bus_ack <= access;
      rd_ram  <= rd && buf_hit;
      rd_q    <= (rd && reg_hit) ? reg_rdata : '0;
    end
  end

  always_comb begin
    dout = '0;
    if (!reset)       dout = '0;
    else if (intack)  dout = {8'h00, vector};
    else if (dma_rd)  dout = ram_q;
    else if (bus_ack) dout = rd_ram ? ram_q : rd_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lba_hi <= '0;
      lba_lo <= '0;
      vector <= '0;
    end else if (wr && reg_hit) begin
      case (reg_off[2:0])
        REG_LBA_HI: lba_hi <= merge_bytes(lba_hi, din, uds, lds);
        REG_LBA_LO: lba_lo <= merge_bytes(lba_lo, din, uds, lds);
        REG_VECTOR: if (lds) vector <= din[7:0];
        default:    ;
      endcase
    end
  end

  always_comb begin
    status_set = '0;
    status_set[ST_READY]    = (state == CHECK) && check_pass;
    status_set[ST_REJECT]   = (state == CHECK) && !check_pass;
    status_set[ST_DMA_DONE] = dma_finish;
    status_clr = (rd && reg_hit && reg_off[2:0] == REG_STATUS) ? 3'b111 : 3'b000;
  end

  // Set events in the same cycle as a read-clear survive it.
  always_ff @(posedge clk) begin
    if (!reset) status <= '0;
    else        status <= (status & ~status_clr) | status_set;
  end

  assign intreq = |status;

  // Sector fetch sequencer
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      fill_idx   <= '0;
      cd_hps_lba <= '0;
    end else begin
      state <= state_nx;
      if (cmd_go) cd_hps_lba <= {lba_hi, lba_lo};
      if (state != FILL)               fill_idx <= '0;
      else if (cd_hps_data_valid)      fill_idx <= fill_idx + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL && cd_hps_data_valid && fill_idx == '0) word0 <= cd_hps_data;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_go) state_nx = REQ;
      REQ:     if (cd_hps_ack) state_nx = FILL;
      FILL:    if (cd_hps_data_valid && fill_idx == LAST_IDX) state_nx = CHECK;
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign cd_hps_req = (state == REQ);

  // Buffer port arbitration: HPS fill first, then CPU, else DMA pointer
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = ptr_addr;
    ram_wdata = din;
    if (state == FILL && cd_hps_data_valid) begin
      ram_we    = 1'b1;
      ram_addr  = fill_idx;
      ram_wdata = cd_hps_data;
    end else if (access && buf_hit) begin
      ram_we   = write_strobe && uds && lds;
      ram_addr = offset[AW-1:0];
    end
  end

  cdic_sector_ram #(.WORDS(SECTOR_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

`ifdef CDIC_DMA_EN
  logic [15:0]   dma_cnt, dma_cnt_new;
  logic [AW-1:0] dma_ptr;
  logic          req_q, done_q, dma_wr;

  assign dma_wr      = wr && reg_hit && reg_off[2:0] == REG_DMACNT;
  assign dma_cnt_new = merge_bytes(dma_cnt, din, uds, lds);
  assign dma_finish  = !dma_wr && !done_in && dtc && dma_cnt == 16'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dma_cnt <= '0;
      dma_ptr <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (dma_wr) begin
        dma_cnt <= dma_cnt_new;
        req_q   <= dma_cnt_new != '0;
        if (dma_cnt_new != '0) dma_ptr <= '0;
      end else if (done_in) begin
        dma_cnt <= '0;
        req_q   <= 1'b0;
      end else if (dtc && dma_cnt != '0) begin
        dma_cnt <= dma_cnt - 16'd1;
        if (dma_ptr != LAST_IDX) dma_ptr <= dma_ptr + AW'(1);
        if (dma_cnt == 16'd1) begin
          req_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign req       = req_q;
  assign done_out  = done_q;
  assign rdy       = reset && ack;
  assign dma_rd    = rdy;
  assign dmacnt_rd = dma_cnt;
  assign ptr_addr  = dma_ptr;
`else
  logic unused_dma;
  assign unused_dma = ^{ack, dtc, done_in};
  assign req        = 1'b0;
  assign done_out   = 1'b0;
  assign rdy        = 1'b0;
  assign dma_rd     = 1'b0;
  assign dma_finish = 1'b0;
  assign dmacnt_rd  = '0;
  assign ptr_addr   = '0;
`endif

  assign audio_left  = '0;
  assign audio_right = '0;

endmodule

// File: tb/tb_cdic.sv
// Scoreboarded random bench for cdic: bus reads queue their expected data,
// a negedge monitor compares whenever bus_ack is presented.
module tb_cdic;

  localparam int          SW   = 1176;
  localparam logic [12:0] BASE = 13'h1FF8;

  logic        clk = 1'b0;
  logic        reset, uds, lds, write_strobe, cs, intack;
  logic [23:1] address;
  logic [15:0] din, dout, cd_hps_data;
  logic        bus_ack, intreq, req, rdy, done_out, ack, dtc, done_in;
  logic [31:0] cd_hps_lba;
  logic        cd_hps_req, cd_hps_ack, cd_hps_data_valid, dis;
  logic signed [15:0] audio_left, audio_right;

  cdic dut (
    .clk(clk), .reset(reset), .address(address), .din(din), .dout(dout),
    .uds(uds), .lds(lds), .write_strobe(write_strobe), .cs(cs),
    .bus_ack(bus_ack), .intreq(intreq), .intack(intack),
    .req(req), .rdy(rdy), .done_out(done_out), .ack(ack), .dtc(dtc), .done_in(done_in),
    .cd_hps_lba(cd_hps_lba), .cd_hps_req(cd_hps_req), .cd_hps_ack(cd_hps_ack),
    .cd_hps_data_valid(cd_hps_data_valid), .cd_hps_data(cd_hps_data),
    .audio_left(audio_left), .audio_right(audio_right),
    .debug_disable_sector_filter(dis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] ref_buf [SW];
  logic [2:0]  status_m;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && bus_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_bus_ack: dout %h with nothing outstanding", dout);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk) check(mon_e.name, {16'd0, dout}, {16'd0, mon_e.val});
      end
    end
  end

  task automatic bus_access(input logic w, input logic [12:0] off, input logic [15:0] d,
                            input logic u, input logic l, input logic chk,
                            input logic [15:0] ev, input string nm, input int hold);
    exp_t e;
    bit   seen;
    e.chk = chk; e.val = ev; e.name = nm;
    exp_q.push_back(e);
    address = {10'd0, off}; din = d; uds = u; lds = l; write_strobe = w; cs = 1'b1;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus_ack) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL bus_ack_timeout %s: no ack within 8 cycles, required 1", nm);
      void'(exp_q.pop_back());
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, "_ack_held_low"}, bus_ack, 0);
    end
    cs = 1'b0; write_strobe = 1'b0; uds = 1'b0; lds = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [12:0] off, input logic [15:0] d, input logic u, input logic l);
    bus_access(1'b1, off, d, u, l, 1'b0, 16'h0, "write", 0);
    if (off < 13'(SW) && u && l) ref_buf[off] = d;
  endtask

  task automatic rd(input logic [12:0] off, input logic [15:0] ev, input string nm);
    bus_access(1'b0, off, 16'h0, 1'b1, 1'b1, 1'b1, ev, nm, 0);
  endtask

  task automatic rd_status(input string nm);
    logic [15:0] ev;
    ev = {13'd0, status_m};
    status_m = '0;
    rd(BASE + 13'd1, ev, nm);
  endtask

  task automatic send_words(input int n, input logic [15:0] w0);
    int i;
    logic [15:0] d;
    i = 0;
    while (i < n) begin
      if ($urandom_range(3) != 0) begin
        d = (i == 0) ? w0 : 16'($urandom);
        cd_hps_data_valid = 1'b1;
        cd_hps_data = d;
        ref_buf[i] = d;
        i++;
      end else begin
        cd_hps_data_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    cd_hps_data_valid = 1'b0;
  endtask

  task automatic start_fetch(input logic [31:0] lba, input logic poke_busy);
    wr(BASE + 13'd2, lba[31:16], 1'b1, 1'b1);
    wr(BASE + 13'd3, lba[15:0], 1'b1, 1'b1);
    wr(BASE, 16'h0001, 1'b1, 1'b1);
    check("hps_req_raised", cd_hps_req, 1);
    check("hps_lba", cd_hps_lba, lba);
    if (poke_busy) begin
      wr(BASE + 13'd3, 16'hFFFF, 1'b1, 1'b1);
      wr(BASE, 16'h0001, 1'b1, 1'b1);
      check("busy_cmd_ignored", cd_hps_lba, lba);
    end
    cd_hps_ack = 1'b1;
    @(posedge clk); #1;
    cd_hps_ack = 1'b0;
    check("hps_req_dropped", cd_hps_req, 0);
  endtask

  task automatic fetch(input logic [31:0] lba, input logic [15:0] w0, input logic fdis,
                       input logic poke_busy);
    dis = fdis;
    start_fetch(lba, poke_busy);
    send_words(SW, w0);
    repeat (3) @(posedge clk);
    #1;
    status_m = status_m | ((w0 == 16'h00FF || fdis) ? 3'b001 : 3'b010);
    check("intreq_after_sector", intreq, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cs = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0;
    address = '0; din = '0; intack = 1'b0; ack = 1'b0; dtc = 1'b0; done_in = 1'b0;
    cd_hps_ack = 1'b0; cd_hps_data_valid = 1'b0; cd_hps_data = '0; dis = 1'b0;
    status_m = '0;
    for (int i = 0; i < SW; i++) ref_buf[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_ack", bus_ack, 0);
    check("rst_intreq", intreq, 0);
    check("rst_hps_req", cd_hps_req, 0);
    check("rst_hps_lba", cd_hps_lba, 0);
    check("rst_dma_outs", {req, rdy, done_out}, 0);
    check("rst_dout", dout, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    rd_status("status_after_reset");
    rd(BASE + 13'd5, 16'h0000, "vector_after_reset");
    check("audio_zero", {audio_left, audio_right}, 0);

    // register byte lanes; ack held cs stays single
    wr(BASE + 13'd2, 16'hFFFF, 1'b1, 1'b1);
    wr(BASE + 13'd2, 16'h1200, 1'b1, 1'b0);
    rd(BASE + 13'd2, 16'h12FF, "lba_hi_uds_only");
    wr(BASE + 13'd2, 16'h0034, 1'b0, 1'b1);
    bus_access(1'b0, BASE + 13'd2, 16'h0, 1'b1, 1'b1, 1'b1, 16'h1234, "lba_hi_lds_only", 3);
    rd(BASE, 16'h0000, "cmd_reads_zero");
    wr(BASE + 13'd5, 16'h005A, 1'b1, 1'b1);
    rd(BASE + 13'd5, 16'h005A, "vector_readback");

    // sector fetch with good sync word, then interrupt handling
    fetch(32'h0000_1234, 16'h00FF, 1'b0, 1'b1);
    intack = 1'b1;
    #1;
    check("intack_vector", dout, 16'h005A);
    intack = 1'b0;
    rd_status("status_ready");
    rd_status("status_cleared");
    check("intreq_cleared", intreq, 0);
    rd(13'd5, ref_buf[5], "buf_word5");
    rd(13'd0, 16'h00FF, "buf_word0");
    rd(13'(SW - 1), ref_buf[SW - 1], "buf_last");
    for (int k = 0; k < 4; k++) begin
      int a;
      a = $urandom_range(SW - 1);
      rd(13'(a), ref_buf[a], "buf_random");
    end

    // CPU buffer writes and unmapped space
    wr(13'd7, 16'hBEEF, 1'b1, 1'b1);
    wr(13'd8, 16'hBEEF, 1'b0, 1'b1);
    rd(13'd7, 16'hBEEF, "buf_cpu_write");
    rd(13'd8, ref_buf[8], "buf_half_write_ignored");
    wr(13'(SW), 16'h5555, 1'b1, 1'b1);
    rd(13'(SW), 16'h0000, "unmapped_after_buf");
    rd(13'h1000, 16'h0000, "unmapped_mid");

    // sector filter
    fetch(32'h0001_0002, 16'hABCD, 1'b0, 1'b0);
    rd_status("status_rejected");
    fetch(32'h0003_0004, 16'hABCD, 1'b1, 1'b0);
    rd_status("status_filter_bypassed");
    dis = 1'b0;

`ifdef CDIC_DMA_EN
    wr(BASE + 13'd4, 16'd3, 1'b1, 1'b1);
    check("dma_req_raised", req, 1);
    for (int k = 0; k < 3; k++) begin
      ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("dma_dout", dout, ref_buf[k]);
      check("dma_rdy", rdy, 1);
      dtc = 1'b1;
      @(posedge clk); #1;
      dtc = 1'b0;
      check("dma_done_pulse", done_out, k == 2);
      check("dma_req_level", req, k < 2);
      ack = 1'b0;
      @(posedge clk); #1;
      check("dma_done_low", done_out, 0);
    end
    status_m = status_m | 3'b100;
    check("dma_intreq", intreq, 1);
    rd(BASE + 13'd4, 16'h0000, "dmacnt_after_done");
    rd_status("status_dma_done");

    wr(BASE + 13'd4, 16'd10, 1'b1, 1'b1);
    rd(BASE + 13'd4, 16'd10, "dmacnt_loaded");
    for (int k = 0; k < 2; k++) begin
      dtc = 1'b1;
      @(posedge clk); #1;
      dtc = 1'b0;
      check("abort_no_done_dtc", done_out, 0);
      @(posedge clk); #1;
    end
    rd(BASE + 13'd4, 16'd8, "dmacnt_decrement");
    done_in = 1'b1;
    @(posedge clk); #1;
    done_in = 1'b0;
    check("abort_req", req, 0);
    check("abort_no_done", done_out, 0);
    @(posedge clk); #1;
    check("abort_no_done_late", done_out, 0);
    rd(BASE + 13'd4, 16'h0000, "dmacnt_aborted");
    check("abort_intreq", intreq, 0);

    wr(BASE + 13'd4, 16'hFFFF, 1'b1, 1'b1);
    for (int k = 0; k < SW + 20; k++) begin
      dtc = 1'b1;
      @(posedge clk); #1;
      dtc = 1'b0;
      @(posedge clk); #1;
    end
    ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("dma_ptr_saturated", dout, ref_buf[SW - 1]);
    ack = 1'b0;
    done_in = 1'b1;
    @(posedge clk); #1;
    done_in = 1'b0;
    check("sat_abort_req", req, 0);
`else
    wr(BASE + 13'd4, 16'd3, 1'b1, 1'b1);
    check("nodma_req", req, 0);
    rd(BASE + 13'd4, 16'h0000, "nodma_dmacnt");
    ack = 1'b1;
    dtc = 1'b1;
    @(posedge clk); #1;
    check("nodma_rdy_done", {rdy, done_out}, 0);
    ack = 1'b0;
    dtc = 1'b0;
    @(posedge clk); #1;
    check("nodma_intreq", intreq, 0);
`endif

    // reset in the middle of a fill
    dis = 1'b0;
    start_fetch(32'h0000_0777, 1'b0);
    send_words(100, 16'h1111);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midfill_hps_req", cd_hps_req, 0);
    check("midfill_lba", cd_hps_lba, 0);
    check("midfill_intreq", intreq, 0);
    reset = 1'b1;
    status_m = '0;
    @(posedge clk); #1;
    rd_status("midfill_status");
    rd(13'd50, ref_buf[50], "midfill_buf_kept");
    fetch(32'h0000_0888, 16'h00FF, 1'b0, 1'b0);
    rd(13'd0, 16'h00FF, "refill_word0");
    rd(13'd99, ref_buf[99], "refill_word99");
    rd(13'd100, ref_buf[100], "refill_word100");
    rd_status("refill_status");

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
